dwconv_psum_pairer: RTL and testbench
=====================================

DWCONV_PSUM_PAIRER -- requirements
Module: dwconv_psum_pairer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of depthwise channels per frame (2..16).
REQ-002 SHALL have parameter CW, default 2, channel index width, equal to clog2(CHANNELS).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  partial-sum valid.
REQ-006 in_ready  output  1  pairer can accept a partial sum.
REQ-007 in_data  input  32  signed kernel partial sum.
REQ-008 flush  input  1  synchronous abort of the current frame.
REQ-009 bias_wr_en  input  1  bias table write strobe.
REQ-010 bias_wr_addr  input  CW  bias table write index.
REQ-011 bias_wr_data  input  32  signed bias value.
REQ-012 output_data  output  [0:63]  packed pair; kernel0 in bits [0:31], kernel1 in bits [32:63].
REQ-013 output_bias  output  32  bias for the emitted channel.
REQ-014 en  output  1  one-cycle strobe marking output_data/output_bias valid for the downstream add cell.
REQ-015 out_ch  output  CW  channel index of the current emission.
REQ-016 frame_done  output  1  one-cycle pulse coincident with en for channel CHANNELS-1.

Function
REQ-017 SHALL consume the input stream in order ch0.k0, ch0.k1, ch1.k0, ch1.k1, ..., ch(CHANNELS-1).k1, then repeat from ch0.
REQ-018 A transfer SHALL occur on a posedge where in_valid and in_ready are both high.
REQ-019 SHALL implement an FSM with states K0, K1 and EMIT; reset state is K0.
REQ-020 In K0, a transfer SHALL latch in_data into output_data[0:31] and move the FSM to K1.
REQ-021 In K1, a transfer SHALL latch in_data into output_data[32:63], latch bias_table[ch] into output_bias, latch ch into out_ch, and move the FSM to EMIT.
REQ-022 In EMIT, en SHALL be 1 for exactly one cycle, in_ready SHALL be 0, and the FSM SHALL return to K0 on the next posedge.
REQ-023 Latency: the k1 transfer at edge t SHALL produce en high during cycle t+1; back-to-back throughput SHALL be one pair per 3 cycles.
REQ-024 in_ready SHALL be 1 in K0 and K1, and 0 in EMIT and while flush is high.
REQ-025 On leaving EMIT, ch SHALL increment; it SHALL wrap from CHANNELS-1 to 0.
REQ-026 frame_done SHALL assert during EMIT when out_ch = CHANNELS-1.
REQ-027 output_data, output_bias and out_ch SHALL hold their values between emissions.
REQ-028 Partial sums SHALL pass unmodified; there is no arithmetic, truncation or saturation on in_data.
REQ-029 bias_table SHALL hold CHANNELS x 32-bit entries; a write SHALL be accepted on any cycle.
REQ-030 If bias_wr_en writes address ch in the same cycle as the k1 transfer, output_bias SHALL receive bias_wr_data (write-through forwarding).
REQ-031 flush high at a posedge SHALL force the FSM to K0 and ch to 0, and drop any held k0.
REQ-032 flush SHALL NOT alter the bias table or the held output_data/output_bias.
REQ-033 If flush and EMIT coincide, en SHALL still complete its current cycle, then the FSM SHALL return to K0 with ch = 0.
REQ-034 in_valid with in_ready low SHALL be ignored; data is not consumed.

Reset
REQ-035 rst high SHALL asynchronously force the FSM to K0 and ch to 0.
REQ-036 rst high SHALL force output_data = 0, output_bias = 0, out_ch = 0, en = 0 and frame_done = 0.
REQ-037 rst high SHALL clear every bias_table entry to 0.
REQ-038 Reset asserted mid-pair SHALL discard the held k0; in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-039 Load biases {10, -20, 30, -40}, then stream 1,2,3,4,5,6,7,8 -> four en pulses with pairs (1,2,b10), (3,4,b-20), (5,6,b30), (7,8,b-40), out_ch 0..3, frame_done on the 4th pulse only.
REQ-040 in_valid held high continuously -> en every 3rd cycle, in_ready low exactly in the EMIT cycles, no data lost or duplicated.
REQ-041 Write bias[1] = 99 in the same cycle as the ch1 k1 transfer -> output_bias = 99 on that emission.
REQ-042 Send k0 = 0x7FFFFFFF, flush, then send 5,6 -> next en carries (5,6), out_ch 0, and 0x7FFFFFFF is never emitted.
REQ-043 Assert rst after a single k0 transfer -> all outputs 0, bias table 0, and the next pair is emitted as ch0.
REQ-044 Send pairs (-1,-2) and (0x80000000,1) -> output_data bit-exact, with no sign or width alteration.

Source files
------------

// File: rtl/dwconv_psum_pairer.sv
// dwconv_psum_pairer: gathers the two kernel partial sums of each depthwise
// channel into one packed pair. The pair is presented together with that
// channel's bias as a single-cycle strobe to the downstream add cell.
module dwconv_psum_pairer #(
   parameter int CHANNELS = 4,
   parameter int CW       = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [31:0]  in_data,
   input  logic                flush,
   input  logic                bias_wr_en,
   input  logic [CW-1:0]       bias_wr_addr,
   input  logic signed [31:0]  bias_wr_data,
   output logic [0:63]         output_data,
   output logic signed [31:0]  output_bias,
   output logic                en,
   output logic [CW-1:0]       out_ch,
   output logic                frame_done
);

   typedef enum logic [1:0] {K0, K1, EMIT} state_t;

   localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      ch;
   logic [CW-1:0]      ch_nxt;
   logic               xfer;
   logic signed [31:0] bias_table [CHANNELS];
   logic signed [31:0] bias_sel;

   // While the pair is being presented, or while a flush is pending, no new sum is taken.
   assign in_ready   = (state != EMIT) && !flush;
   assign xfer       = in_valid && in_ready;
   assign en         = (state == EMIT);
   assign frame_done = en && (out_ch == LAST_CH);

   // A bias written to the current channel in the k1 cycle is forwarded, so the
   // emission never sees a stale entry.
   assign bias_sel = (bias_wr_en && (bias_wr_addr == ch)) ? bias_wr_data : bias_table[ch];

   // Next-state and channel-advance logic; flush overrides everything.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt = state;
      ch_nxt    = ch;
      unique case (state)
         K0:      if (xfer) state_nxt = K1;
         K1:      if (xfer) state_nxt = EMIT;
         EMIT: begin
            state_nxt = K0;
            ch_nxt    = (ch == LAST_CH) ? '0 : ch + CW'(1);
         end
         default: state_nxt = K0;
      endcase
      if (flush) begin
         state_nxt = K0;
         ch_nxt    = '0;
      end
   end

   // State and channel-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (rst) begin
         state <= K0;
         ch    <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   // Output pair, bias and channel capture; these hold between emissions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         output_data <= '0;
         output_bias <= '0;
         out_ch      <= '0;
      end else if (xfer) begin
         if (state == K0) begin
            output_data[0:31] <= in_data;
         end else if (state == K1) begin
            output_data[32:63] <= in_data;
            output_bias        <= bias_sel;
            out_ch             <= ch;
         end
      end
   end

   // Bias table: a write is accepted on any cycle, and flush leaves the table alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the table is small and must read as zero after reset, so it is built from reset flops rather than RAM.
         for (int i = 0; i < CHANNELS; i++) bias_table[i] <= '0;
      end else if (bias_wr_en) begin
         bias_table[bias_wr_addr] <= bias_wr_data;
      end
   end

endmodule

// File: tb/tb_dwconv_psum_pairer.sv
// Self-checking bench for dwconv_psum_pairer. A stream-position model predicts
// every cycle's outputs, and each scenario task also checks the emissions it
// produced against fixed expectations.
module tb_dwconv_psum_pairer;

   localparam int C  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          flush;
   logic          bias_wr_en;
   logic [CW-1:0] bias_wr_addr;
   logic [31:0]   bias_wr_data;
   logic [0:63]   output_data;
   logic [31:0]   output_bias;
   logic          en;
   logic [CW-1:0] out_ch;
   logic          frame_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: position within the 2*C-long frame stream, plus the
   // values the outputs are expected to carry.
   int            m_idx;
   bit            m_emit;
   logic [31:0]   m_k0, m_k1, m_bias;
   logic [CW-1:0] m_ch;
   logic [31:0]   m_tab [C];

   typedef struct {
      logic [31:0]   k0;
      logic [31:0]   k1;
      logic [31:0]   bias;
      logic [CW-1:0] ch;
      logic          fd;
      int            cyc;
   } em_t;
   em_t log_q[$];

   dwconv_psum_pairer #(.CHANNELS(C), .CW(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .flush        (flush),
      .bias_wr_en   (bias_wr_en),
      .bias_wr_addr (bias_wr_addr),
      .bias_wr_data (bias_wr_data),
      .output_data  (output_data),
      .output_bias  (output_bias),
      .en           (en),
      .out_ch       (out_ch),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      m_idx  = 0;
      m_emit = 0;
      m_k0   = '0;
      m_k1   = '0;
      m_bias = '0;
      m_ch   = '0;
      for (int i = 0; i < C; i++) m_tab[i] = '0;
   endtask

   // One clock cycle: inputs are driven at the negedge, in_ready is checked
   // shortly after, and the registered outputs are checked at the following negedge.
   task automatic cycle(input bit v, input logic [31:0] d, input bit fl, input bit bwe,
                        input logic [CW-1:0] ba, input logic [31:0] bd, output bit took);
      bit          rdy;
      int          c;
      logic [0:63] want_data;
      logic        want_fd;
      in_valid = v; in_data = d; flush = fl;
      bias_wr_en = bwe; bias_wr_addr = ba; bias_wr_data = bd;
      #1;
      rdy = !m_emit && !fl;
      total++;
      if (in_ready !== rdy) begin
         bad++;
         $display("FAIL in_ready @%0d: got %b want %b", cyc, in_ready, rdy);
      end
      took = rdy && v;
      @(posedge clk);
      c      = m_idx / 2;
      m_emit = 0;
      if (took) begin
         if (m_idx % 2 == 0) begin
            m_k0 = d;
         end else begin
            m_k1   = d;
            m_bias = (bwe && int'(ba) == c) ? bd : m_tab[c];
            m_ch   = CW'(c);
            m_emit = 1;
         end
         m_idx = (m_idx + 1) % (2 * C);
      end
      if (bwe) m_tab[ba] = bd;
      if (fl) m_idx = 0;
      @(negedge clk);
      cyc++;
      want_data = {m_k0, m_k1};
      want_fd   = m_emit && (m_ch == CW'(C - 1));
      total++;
      if (en !== m_emit) begin
         bad++;
         $display("FAIL en @%0d: got %b want %b", cyc, en, m_emit);
      end
      total++;
      if (frame_done !== want_fd) begin
         bad++;
         $display("FAIL frame_done @%0d: got %b want %b", cyc, frame_done, want_fd);
      end
      total++;
      if (output_data !== want_data) begin
         bad++;
         $display("FAIL output_data @%0d: got %h want %h", cyc, output_data, want_data);
      end
      total++;
      if (output_bias !== m_bias) begin
         bad++;
         $display("FAIL output_bias @%0d: got %h want %h", cyc, output_bias, m_bias);
      end
      total++;
      if (out_ch !== m_ch) begin
         bad++;
         $display("FAIL out_ch @%0d: got %0d want %0d", cyc, out_ch, m_ch);
      end
      if (en === 1'b1)
         log_q.push_back('{output_data[0:31], output_data[32:63], output_bias, out_ch, frame_done, cyc});
   endtask

   task automatic idle(input int n);
      bit took;
      for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0, '0, took);
   endtask

   task automatic wr_bias(input logic [CW-1:0] a, input logic [31:0] d);
      bit took;
      cycle(0, '0, 0, 1, a, d, took);
   endtask

   // Holds one partial sum on the input until it is accepted, within a small cycle budget.
   task automatic send(input logic [31:0] d);
      bit took;
      int n = 0;
      do begin
         cycle(1, d, 0, 0, '0, '0, took);
         n++;
      end while (!took && n < 8);
      total++;
      if (!took) begin
         bad++;
         $display("FAIL send_timeout: got no transfer want transfer of %h", d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 0; in_data = '0; flush = 0;
      bias_wr_en = 0; bias_wr_addr = '0; bias_wr_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (output_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", output_data); end
      total++; if (output_bias !== '0) begin bad++; $display("FAIL reset_bias: got %h want 0", output_bias); end
      total++; if (out_ch !== '0) begin bad++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
      total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", en); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_frame();
      int exp_b[4] = '{10, -20, 30, -40};
      wr_bias(0, 32'(10)); wr_bias(1, 32'(-20)); wr_bias(2, 32'(30)); wr_bias(3, 32'(-40));
      log_q.delete();
      for (int i = 1; i <= 8; i++) send(32'(i));
      idle(2);
      total++;
      if (log_q.size() != 4) begin
         bad++;
         $display("FAIL frame_count: got %0d want 4", log_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (log_q[i].k0 !== 32'(2*i+1) || log_q[i].k1 !== 32'(2*i+2) || log_q[i].bias !== 32'(exp_b[i])
                || log_q[i].ch !== CW'(i) || log_q[i].fd !== (i == 3)) begin
               bad++;
               $display("FAIL frame_pair%0d: got (%0d,%0d,b%0d,ch%0d,fd%b) want (%0d,%0d,b%0d,ch%0d,fd%b)", i,
                        log_q[i].k0, log_q[i].k1, $signed(log_q[i].bias), log_q[i].ch, log_q[i].fd,
                        2*i+1, 2*i+2, exp_b[i], i, i == 3);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit            took;
      logic [31:0]   d = 32'd100;
      log_q.delete();
      for (int i = 0; i < 24; i++) begin
         cycle(1, d, 0, 0, '0, '0, took);
         if (took) d++;
      end
      idle(1);
      total++;
      if (log_q.size() != 8) begin
         bad++;
         $display("FAIL b2b_count: got %0d want 8", log_q.size());
      end else begin
         for (int j = 0; j < 8; j++) begin
            total++;
            if (log_q[j].k0 !== 32'(100 + 2*j) || log_q[j].k1 !== 32'(101 + 2*j)) begin
               bad++;
               $display("FAIL b2b_pair%0d: got (%0d,%0d) want (%0d,%0d)", j, log_q[j].k0, log_q[j].k1, 100+2*j, 101+2*j);
            end
            if (j > 0) begin
               total++;
               if (log_q[j].cyc - log_q[j-1].cyc != 3) begin
                  bad++;
                  $display("FAIL b2b_spacing%0d: got %0d want 3", j, log_q[j].cyc - log_q[j-1].cyc);
               end
            end
         end
      end
   endtask

   task automatic test_bias_forward();
      bit took;
      cycle(0, '0, 1, 0, '0, '0, took);
      send(32'd11); send(32'd12); send(32'd13);
      log_q.delete();
      cycle(1, 32'd14, 0, 1, 2'd1, 32'd99, took);
      total++;
      if (!took) begin bad++; $display("FAIL fwd_transfer: got no transfer want transfer"); end
      idle(1);
      total++;
      if (log_q.size() != 1 || log_q[0].bias !== 32'd99 || log_q[0].ch !== 2'd1) begin
         bad++;
         $display("FAIL fwd_bias: got %0d emissions bias %0d want 1 emission bias 99 ch1", log_q.size(),
                  log_q.size() > 0 ? log_q[0].bias : 32'd0);
      end
   endtask

   task automatic test_flush();
      bit took;
      send(32'h7FFF_FFFF);
      cycle(0, '0, 1, 0, '0, '0, took);
      log_q.delete();
      send(32'd5); send(32'd6);
      idle(1);
      total++;
      if (log_q.size() != 1 || log_q[0].k0 !== 32'd5 || log_q[0].k1 !== 32'd6 || log_q[0].ch !== '0) begin
         bad++;
         $display("FAIL flush_k0: got %0d emissions first (%h,%h) want one (5,6) ch0", log_q.size(),
                  log_q.size() > 0 ? log_q[0].k0 : 32'd0, log_q.size() > 0 ? log_q[0].k1 : 32'd0);
      end
      // Flush coinciding with the emission cycle: the strobe completes, the next pair is ch0.
      send(32'd7); send(32'd8);
      cycle(1, 32'd9, 1, 0, '0, '0, took);
      log_q.delete();
      send(32'd9); send(32'd10);
      idle(1);
      total++;
      if (log_q.size() != 1 || log_q[0].ch !== '0 || log_q[0].k0 !== 32'd9) begin
         bad++;
         $display("FAIL flush_emit: got %0d emissions ch %0d want one emission ch0 k0=9", log_q.size(),
                  log_q.size() > 0 ? log_q[0].ch : 2'd0);
      end
   endtask

   task automatic test_reset_mid_pair();
      wr_bias(0, 32'd77);
      send(32'h55);
      rst = 1'b1; in_valid = 0;
      #1;
      total++; if (output_data !== '0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", output_data); end
      total++; if (output_bias !== '0) begin bad++; $display("FAIL mid_rst_bias: got %h want 0", output_bias); end
      total++; if (out_ch !== '0) begin bad++; $display("FAIL mid_rst_ch: got %0d want 0", out_ch); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      log_q.delete();
      send(32'd21); send(32'd22);
      idle(1);
      total++;
      if (log_q.size() != 1 || log_q[0].k0 !== 32'd21 || log_q[0].k1 !== 32'd22 || log_q[0].bias !== '0 || log_q[0].ch !== '0) begin
         bad++;
         $display("FAIL mid_rst_pair: got %0d emissions want one (21,22,b0,ch0)", log_q.size());
      end
   endtask

   task automatic test_extremes();
      log_q.delete();
      send(32'hFFFF_FFFF); send(32'hFFFF_FFFE); send(32'h8000_0000); send(32'h0000_0001);
      idle(1);
      total++;
      if (log_q.size() != 2 || log_q[0].k0 !== 32'hFFFF_FFFF || log_q[0].k1 !== 32'hFFFF_FFFE
          || log_q[1].k0 !== 32'h8000_0000 || log_q[1].k1 !== 32'h0000_0001) begin
         bad++;
         $display("FAIL extremes: got %0d emissions want (ffffffff,fffffffe) and (80000000,00000001)", log_q.size());
      end
   endtask

   task automatic test_random();
      bit took;
      log_q.delete();
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(3, 0) != 0, $urandom, $urandom_range(29, 0) == 0,
               $urandom_range(4, 0) == 0, CW'($urandom_range(C-1, 0)), $urandom, took);
      total++;
      if (log_q.size() < 20) begin
         bad++;
         $display("FAIL random_activity: got %0d emissions want at least 20", log_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_bias_forward();
      test_flush();
      test_reset_mid_pair();
      test_extremes();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
